// File: rtl/qdriip_ref_pkg.sv
// Shared QDRII+ reference-traffic definitions: widths, the address-derived data
// pattern and the checker FSM states. The writer imports this too.
package qdriip_ref_pkg;

  localparam int QDR_ADDR_W = 22;
  localparam int QDR_BEAT_W = 18;
  localparam int QDR_DATA_W = 4 * QDR_BEAT_W;

  localparam logic [QDR_BEAT_W-1:0] PATTERN_KEY = 18'h2A5A5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } qdr_state_e;

  // Same 18-bit beat repeated on all four BL4 beats.
  function automatic logic [QDR_DATA_W-1:0] qdr_pattern(input logic [QDR_ADDR_W-1:0] addr);
    logic [QDR_BEAT_W-1:0] beat;
    beat = addr[QDR_BEAT_W-1:0] ^ PATTERN_KEY;
    return {4{beat}};
  endfunction

endpackage

// File: rtl/qdriip_rd_tracker.sv
// Read bookkeeping for the readback checker: outstanding-read count, in-order
// return count and the no-response watchdog.
module qdriip_rd_tracker #(
  parameter int MAX_OUTSTANDING = 16,
  parameter int TIMEOUT_CYCLES  = 4096,
  parameter int RET_W           = 4
) (
  input  logic             clk,
  input  logic             sys_rst,
  input  logic             active_i,
  input  logic             cmd_i,
  input  logic             valid_i,
  output logic [RET_W-1:0] ret_cnt_o,
  output logic             ret_ok_o,
  output logic             spurious_o,
  output logic             at_max_o,
  output logic             timeout_hit_o
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [OUT_W-1:0] out_cnt_q, out_cnt_d;
  logic [RET_W-1:0] ret_cnt_q, ret_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             ret_ok;

  // A return with nothing outstanding is spurious and never decrements.
  assign ret_ok        = valid_i && (out_cnt_q != '0);
  assign ret_ok_o      = ret_ok;
  assign spurious_o    = valid_i && (out_cnt_q == '0);
  assign at_max_o      = (out_cnt_q == OUT_W'(MAX_OUTSTANDING));
  assign ret_cnt_o     = ret_cnt_q;
  assign timeout_hit_o = active_i && !valid_i && (out_cnt_q != '0) &&
                         (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    // NOTE: defaults first, so no path leaves a variable unassigned and infers a latch.
    out_cnt_d = out_cnt_q;
    ret_cnt_d = ret_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    if (cmd_i && !ret_ok) begin
      out_cnt_d = out_cnt_q + OUT_W'(1);
    end else if (!cmd_i && ret_ok) begin
      out_cnt_d = out_cnt_q - OUT_W'(1);
    end
    if (ret_ok) begin
      ret_cnt_d = ret_cnt_q + RET_W'(1);
    end
    if (valid_i) begin
      tmo_cnt_d = '0;
    end else if (active_i && (out_cnt_q != '0)) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (sys_rst) begin
      out_cnt_q <= '0;
      ret_cnt_q <= '0;
      tmo_cnt_q <= '0;
    end else begin
      out_cnt_q <= out_cnt_d;
      ret_cnt_q <= ret_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

endmodule

// File: rtl/qdriip_readback_checker.sv
// QDRII+ readback checker: issues NUM_READS BL4 reads after the writer finishes and
// compares returns to the address pattern. Macro QDRIIP_CHK_ERR_CAPTURE_EN adds first-error capture.
module qdriip_readback_checker
  import qdriip_ref_pkg::*;
#(
  parameter int NUM_READS       = 10,
  parameter int ADDR_W          = 22,
  parameter int DATA_W          = 72,
  parameter int START_ADDR      = 0,
  parameter int MAX_OUTSTANDING = 16,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic              init_calib_complete,
  output logic              app_rd_cmd0,
  output logic [ADDR_W-1:0] app_rd_addr0,
  input  logic              app_rd_valid0,
  input  logic [DATA_W-1:0] app_rd_data0,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic              timeout,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data
);

  localparam int RET_W = $clog2(NUM_READS + 2);

  qdr_state_e       state_q, state_d;
  logic             start_pend_q, start_pend_d;
  logic [RET_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [15:0]      err_count_q, err_count_d;
  logic             timeout_q, timeout_d;

  logic             active, valid_in, cmd;
  logic [RET_W-1:0] ret_cnt;
  logic             ret_ok, spurious, at_max, timeout_hit;
  logic [ADDR_W-1:0] exp_addr;
  logic             mismatch;

  // Returns outside ISSUE/DRAIN (e.g. in flight across a reset) are ignored.
  assign active   = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign valid_in = app_rd_valid0 && active;
  assign cmd      = (state_q == ST_ISSUE) && !at_max;

  qdriip_rd_tracker #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .TIMEOUT_CYCLES  (TIMEOUT_CYCLES),
    .RET_W           (RET_W)
  ) u_tracker (
    .clk           (clk),
    .sys_rst       (sys_rst),
    .active_i      (active),
    .cmd_i         (cmd),
    .valid_i       (valid_in),
    .ret_cnt_o     (ret_cnt),
    .ret_ok_o      (ret_ok),
    .spurious_o    (spurious),
    .at_max_o      (at_max),
    .timeout_hit_o (timeout_hit)
  );

  assign exp_addr = ADDR_W'(START_ADDR) + ADDR_W'(ret_cnt);
  assign mismatch = ret_ok &&
                    (app_rd_data0 != DATA_W'(qdr_pattern(QDR_ADDR_W'(exp_addr))));

  always_comb begin
    state_d      = state_q;
    start_pend_d = start_pend_q;
    issue_cnt_d  = issue_cnt_q;
    err_count_d  = err_count_q;
    timeout_d    = timeout_q;

    if ((mismatch || spurious) && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end
    if (cmd) begin
      issue_cnt_d = issue_cnt_q + RET_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if ((start || start_pend_q) && init_calib_complete) begin
          state_d      = (NUM_READS == 0) ? ST_DONE : ST_ISSUE;
          start_pend_d = 1'b0;
        end else if (start) begin
          start_pend_d = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (timeout_hit) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
        end else if (cmd && (issue_cnt_q == RET_W'(NUM_READS - 1))) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (timeout_hit) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
        end else if ((ret_cnt == RET_W'(NUM_READS)) ||
                     (ret_ok && (ret_cnt == RET_W'(NUM_READS - 1)))) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_DONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q      <= ST_IDLE;
      start_pend_q <= 1'b0;
      issue_cnt_q  <= '0;
      err_count_q  <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_pend_q <= start_pend_d;
      issue_cnt_q  <= issue_cnt_d;
      err_count_q  <= err_count_d;
      timeout_q    <= timeout_d;
    end
  end

  assign app_rd_cmd0  = cmd;
  assign app_rd_addr0 = cmd ? (ADDR_W'(START_ADDR) + ADDR_W'(issue_cnt_q)) : '0;
  assign done         = (state_q == ST_DONE);
  assign pass         = done && (err_count_q == '0) && !timeout_q;
  assign err_count    = err_count_q;
  assign timeout      = timeout_q;

`ifdef QDRIIP_CHK_ERR_CAPTURE_EN
  logic              cap_vld_q;
  logic [ADDR_W-1:0] cap_addr_q;
  logic [DATA_W-1:0] cap_data_q;

  always_ff @(posedge clk) begin
    // NOTE: capture registers are reset so the ports read 0 until a mismatch, never X.
    if (sys_rst) begin
      cap_vld_q  <= 1'b0;
      cap_addr_q <= '0;
      cap_data_q <= '0;
    end else if (mismatch && !cap_vld_q) begin
      cap_vld_q  <= 1'b1;
      cap_addr_q <= exp_addr;
      cap_data_q <= app_rd_data0;
    end
  end

  assign first_err_addr = cap_addr_q;
  assign first_err_data = cap_data_q;
`else
  assign first_err_addr = '0;
  assign first_err_data = '0;
`endif

endmodule

// File: tb/tb_qdriip_readback_checker.sv
// Randomized bench for qdriip_readback_checker: an in-order memory responder with
// random latency plus a positional model of expected errors, timeout and latency.
module tb_qdriip_readback_checker;

  localparam int NR   = 64;
  localparam int MAXO = 16;
  localparam int TMO  = 100;
  localparam int SA   = 0;

  logic        clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        start = 1'b0;
  logic        init_calib_complete = 1'b0;
  logic        app_rd_cmd0;
  logic [21:0] app_rd_addr0;
  logic        app_rd_valid0 = 1'b0;
  logic [71:0] app_rd_data0 = '0;
  logic        done, pass, timeout;
  logic [15:0] err_count;
  logic [21:0] first_err_addr;
  logic [71:0] first_err_data;

  qdriip_readback_checker #(
    .NUM_READS       (NR),
    .ADDR_W          (22),
    .DATA_W          (72),
    .START_ADDR      (SA),
    .MAX_OUTSTANDING (MAXO),
    .TIMEOUT_CYCLES  (TMO)
  ) u_dut (
    .clk                 (clk),
    .sys_rst             (sys_rst),
    .start               (start),
    .init_calib_complete (init_calib_complete),
    .app_rd_cmd0         (app_rd_cmd0),
    .app_rd_addr0        (app_rd_addr0),
    .app_rd_valid0       (app_rd_valid0),
    .app_rd_data0        (app_rd_data0),
    .done                (done),
    .pass                (pass),
    .err_count           (err_count),
    .timeout             (timeout),
    .first_err_addr      (first_err_addr),
    .first_err_data      (first_err_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [71:0] tb_pattern(input int a);
    logic [17:0] b;
    b = 18'(a) ^ 18'h2A5A5;
    return {b, b, b, b};
  endfunction

  typedef struct {
    int addr;
    int due;
  } rd_t;

  rd_t         pend[$];
  int          lat_lo = 20, lat_hi = 20, corrupt_addr = -1, drop_addr = -1;
  bit          spur_en = 1'b0;
  int          n_cmd, n_ok, exp_err, max_out, last_due, first_cmd_cyc, last_valid_cyc, calib_cyc;
  bit          have_first;
  int          exp_first_addr;
  logic [71:0] exp_first_data;

  // Responder + model: outstanding is cmds seen minus non-spurious returns; each
  // delivered word is judged against the pattern of its position in return order.
  always @(negedge clk) begin
    int          out_now;
    bit          dlv;
    logic [71:0] d;
    rd_t         r;
    if (sys_rst) begin
      pend.delete();
      n_cmd = 0; n_ok = 0; exp_err = 0; max_out = 0; last_due = 0;
      first_cmd_cyc = -1; last_valid_cyc = -1;
      have_first = 1'b0; exp_first_addr = 0; exp_first_data = '0;
      app_rd_valid0 = 1'b0; app_rd_data0 = '0;
    end else begin
      out_now = n_cmd - n_ok;
      if (out_now > max_out) max_out = out_now;
      dlv = 1'b0;
      d = '0;
      app_rd_valid0 = 1'b0;
      if (spur_en && app_rd_cmd0 && n_cmd == 0) begin
        dlv = 1'b1;
        d = tb_pattern(SA);
      end else if (pend.size() > 0 && pend[0].due <= cyc) begin
        r = pend.pop_front();
        if (r.addr != drop_addr) begin
          dlv = 1'b1;
          d = tb_pattern(r.addr);
          if (r.addr == corrupt_addr) d[0] = ~d[0];
        end
      end
      if (dlv) begin
        app_rd_valid0 = 1'b1;
        app_rd_data0 = d;
        last_valid_cyc = cyc;
        if (out_now == 0) begin
          exp_err++;
        end else begin
          if (d != tb_pattern(SA + n_ok)) begin
            exp_err++;
            if (!have_first) begin
              have_first = 1'b1;
              exp_first_addr = SA + n_ok;
              exp_first_data = d;
            end
          end
          n_ok++;
        end
      end
      if (app_rd_cmd0) begin
        check("cmd_addr", 72'(app_rd_addr0), 72'(SA + n_cmd));
        check("cmd_room", 72'(out_now < MAXO && n_cmd < NR), 72'(1));
        r.addr = SA + n_cmd;
        r.due = cyc + int'($urandom_range(lat_hi, lat_lo));
        if (r.due <= last_due) r.due = last_due + 1;
        last_due = r.due;
        pend.push_back(r);
        n_cmd++;
        if (first_cmd_cyc < 0) first_cmd_cyc = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ":done"}, 72'(done), 72'(0));
    check({tag, ":pass"}, 72'(pass), 72'(0));
    check({tag, ":err"}, 72'(err_count), 72'(0));
    check({tag, ":tmo"}, 72'(timeout), 72'(0));
    check({tag, ":cmd"}, 72'(app_rd_cmd0), 72'(0));
    check({tag, ":addr"}, 72'(app_rd_addr0), 72'(0));
    check({tag, ":fea"}, 72'(first_err_addr), 72'(0));
    check({tag, ":fed"}, first_err_data, 72'(0));
  endtask

  task automatic begin_case(input int lo, input int hi, input int corrupt, input int drop,
                            input bit spur, input int calib_delay);
    lat_lo = lo; lat_hi = hi; corrupt_addr = corrupt; drop_addr = drop; spur_en = spur;
    init_calib_complete = (calib_delay == 0);
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    if (calib_delay > 0) begin
      repeat (calib_delay - 1) step();
      check("calib_hold", 72'(n_cmd), 72'(0));
      init_calib_complete = 1'b1;
      calib_cyc = cyc;
    end
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int i = 0; i < 20000; i++) begin
      if (done) begin
        dc = cyc;
        break;
      end
      step();
    end
    if (dc < 0) check("done_bound", 72'(done), 72'(1));
  endtask

  task automatic finish_case(input string tag, input bit exp_to, input int dc);
    int e;
    int d;
    e = (exp_err > 65535) ? 65535 : exp_err;
    check({tag, ":err"}, 72'(err_count), 72'(e));
    check({tag, ":tmo"}, 72'(timeout), 72'(exp_to));
    check({tag, ":pass"}, 72'(pass), 72'(e == 0 && !exp_to));
    if (!exp_to) begin
      check({tag, ":ncmd"}, 72'(n_cmd), 72'(NR));
      check({tag, ":done_lat"}, 72'(dc), 72'(last_valid_cyc + 1));
    end else begin
      // Watchdog counts TMO idle cycles after the clearing return, then registers.
      d = dc - last_valid_cyc;
      check({tag, ":tmo_lat"}, 72'(d), 72'((d == TMO) ? TMO : TMO + 1));
    end
`ifdef QDRIIP_CHK_ERR_CAPTURE_EN
    check({tag, ":fea"}, 72'(first_err_addr), 72'(have_first ? exp_first_addr : 0));
    check({tag, ":fed"}, first_err_data, have_first ? exp_first_data : 72'(0));
`else
    check({tag, ":fea"}, 72'(first_err_addr), 72'(0));
    check({tag, ":fed"}, first_err_data, 72'(0));
`endif
  endtask

  initial begin
    int dc;
    int c;
    repeat (3) step();
    do_reset();
    check_idle("reset");

    begin_case(20, 20, -1, -1, 1'b0, 0);
    wait_done(dc);
    finish_case("basic", 1'b0, dc);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (20) step();
    check("restart_ignored", 72'(n_cmd), 72'(NR));
    check("done_hold", 72'(done), 72'(1));

    begin_case(5, 40, 5, -1, 1'b0, 0);
    wait_done(dc);
    finish_case("corrupt5", 1'b0, dc);

    for (int k = 0; k < 3; k++) begin
      c = int'($urandom_range(0, 95));
      begin_case(1, int'($urandom_range(1, 60)), c, -1, 1'b0, 0);
      wait_done(dc);
      finish_case("random", 1'b0, dc);
    end

    begin_case(40, 40, -1, -1, 1'b0, 0);
    wait_done(dc);
    finish_case("backpressure", 1'b0, dc);
    check("bp_peak", 72'(max_out), 72'(MAXO));

    begin_case(20, 20, -1, 3, 1'b0, 0);
    wait_done(dc);
    finish_case("timeout", 1'b1, dc);

    begin_case(10, 30, -1, -1, 1'b1, 0);
    wait_done(dc);
    finish_case("spurious", 1'b0, dc);

    begin_case(20, 20, -1, -1, 1'b0, 50);
    wait_done(dc);
    check("calib_first_cmd", 72'(first_cmd_cyc), 72'(calib_cyc + 1));
    finish_case("calib", 1'b0, dc);

    begin_case(20, 20, -1, -1, 1'b0, 0);
    for (int i = 0; i < 1000 && n_ok < 4; i++) step();
    check("midrst_progress", 72'(n_ok >= 4), 72'(1));
    sys_rst = 1'b1;
    step();
    check_idle("midrst");
    sys_rst = 1'b0;
    begin_case(20, 20, -1, -1, 1'b0, 0);
    wait_done(dc);
    finish_case("rerun", 1'b0, dc);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
